// File: rtl/pwm_pkg.sv
// Shared types and default widths for the center-aligned PWM output stage.
package pwm_pkg;

    localparam int CW_DEF  = 32;
    localparam int DTW_DEF = 8;

    typedef enum logic [2:0] {
        OFF,
        LOW_ON,
        DT_H,
        HIGH_ON,
        DT_L
    } db_state_e;

endpackage

// File: rtl/center_pwm_if.sv
// Compare-value write channel: valid/ready transfer of a new duty compare value.
interface center_pwm_if
    import pwm_pkg::*;
#(
    parameter int CW = CW_DEF
);

    logic [CW-1:0] cmp_wdata;
    logic          cmp_wvld;
    logic          cmp_wrdy;

    modport master (output cmp_wdata, output cmp_wvld, input  cmp_wrdy);
    modport slave  (input  cmp_wdata, input  cmp_wvld, output cmp_wrdy);

endinterface

// File: rtl/pwm_deadband.sv
// Dead-band state machine: turns the raw compare result into a non-overlapping
// high-side/low-side pair with a programmable gap between the two.
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int DTW = DTW_DEF
)
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           raw,
    input  logic [DTW-1:0] dead_cfg,
    output logic           pwm_h,
    output logic           pwm_l
);

    db_state_e      state;
    db_state_e      state_nxt;
    logic [DTW-1:0] dt_cnt;
    logic [DTW-1:0] dt_nxt;
    logic           dead_zero;

    assign dead_zero = (dead_cfg == '0);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_nxt = state;
        dt_nxt    = dt_cnt;
        if (!en) begin
            state_nxt = OFF;
            dt_nxt    = '0;
        end else begin
            case (state)
                OFF, LOW_ON, HIGH_ON: begin
                    if (raw && state != HIGH_ON) begin
                        state_nxt = dead_zero ? HIGH_ON : DT_H;
                        dt_nxt    = dead_cfg;
                    end else if (!raw && state != LOW_ON) begin
                        state_nxt = dead_zero ? LOW_ON : DT_L;
                        dt_nxt    = dead_cfg;
                    end
                end
                DT_H: begin
                    if (!raw) begin
                        // Edge reversed mid-gap: restart the full gap toward the low side.
                        state_nxt = dead_zero ? LOW_ON : DT_L;
                        dt_nxt    = dead_cfg;
                    end else if (dt_cnt <= DTW'(1)) begin
                        state_nxt = HIGH_ON;
                        dt_nxt    = '0;
                    end else begin
                        dt_nxt    = dt_cnt - DTW'(1);
                    end
                end
                DT_L: begin
                    if (raw) begin
                        state_nxt = dead_zero ? HIGH_ON : DT_H;
                        dt_nxt    = dead_cfg;
                    end else if (dt_cnt <= DTW'(1)) begin
                        state_nxt = LOW_ON;
                        dt_nxt    = '0;
                    end else begin
                        dt_nxt    = dt_cnt - DTW'(1);
                    end
                end
                default: begin
                    state_nxt = OFF;
                    dt_nxt    = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= OFF;
            dt_cnt <= '0;
            pwm_h  <= 1'b0;
            pwm_l  <= 1'b0;
        end else begin
            state  <= state_nxt;
            dt_cnt <= dt_nxt;
            pwm_h  <= (state_nxt == HIGH_ON);
            pwm_l  <= (state_nxt == LOW_ON);
        end
    end

endmodule

// File: rtl/center_pwm.sv
// Center-aligned PWM: valley detect on the triangle count, double-buffered
// compare value, and a dead-band driven complementary output pair.
module center_pwm
    import pwm_pkg::*;
#(
    parameter int CW  = CW_DEF,
    parameter int DTW = DTW_DEF
)
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [CW-1:0]  cnt,
    center_pwm_if.slave    cmp_if,
    input  logic [DTW-1:0] dead_cfg,
    output logic           pwm_h,
    output logic           pwm_l,
    output logic           valley_pls
);

    logic          en_d;
    logic [CW-1:0] cnt_d;
    logic          valley;
    logic [CW-1:0] pend;
    logic [CW-1:0] active;
    logic          pend_vld;
    logic          wr_xfer;
    logic          raw;

    // The timer holds zero for two cycles at enable; the previous-sample terms
    // make that pair count as a single valley.
    assign valley = en & (cnt == '0) & (~en_d | (cnt_d != '0));

    assign cmp_if.cmp_wrdy = ~pend_vld;
    assign wr_xfer         = cmp_if.cmp_wvld & ~pend_vld;
    assign raw             = en & (cnt < active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d       <= 1'b0;
            cnt_d      <= '0;
            valley_pls <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            en_d       <= en;
            cnt_d      <= cnt;
            valley_pls <= valley;
        end
    end

    // A write accepted needs ~pend_vld and a swap needs pend_vld, so the two
    // never collide; a write landing in a valley waits for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            pend_vld <= 1'b0;
            active   <= '0;
        end else if (wr_xfer) begin
            pend     <= cmp_if.cmp_wdata;
            pend_vld <= 1'b1;
        end else if (valley && pend_vld) begin
            active   <= pend;
            pend_vld <= 1'b0;
        end
    end

    pwm_deadband #(
        .DTW (DTW)
    ) u_deadband (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .raw      (raw),
        .dead_cfg (dead_cfg),
        .pwm_h    (pwm_h),
        .pwm_l    (pwm_l)
    );

endmodule

// File: tb/tb_center_pwm.sv
// Directed bench for center_pwm: triangle count with max=4, per-cycle expected
// outputs written as strings ('H' high side, 'L' low side, '-' both off).
module tb_center_pwm;

    localparam int CW  = 32;
    localparam int DTW = 8;
    localparam int MAX = 4;
    localparam int PER = 2 * MAX;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic [CW-1:0]  cnt;
    logic [DTW-1:0] dead_cfg;
    logic           pwm_h;
    logic           pwm_l;
    logic           valley_pls;

    int n_cmp = 0;
    int n_err = 0;

    center_pwm_if #(.CW(CW)) cmp_if ();

    center_pwm #(
        .CW  (CW),
        .DTW (DTW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cnt        (cnt),
        .cmp_if     (cmp_if),
        .dead_cfg   (dead_cfg),
        .pwm_h      (pwm_h),
        .pwm_l      (pwm_l),
        .valley_pls (valley_pls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Timer model: 0,0,1,..,MAX,..,1,0,1,.. from the first enabled cycle.
    function automatic logic [CW-1:0] timer_cnt(input int i);
        int p;
        if (i == 0) return '0;
        p = (i - 1) % PER;
        return (p <= MAX) ? CW'(p) : CW'(PER - p);
    endfunction

    task automatic do_reset();
        rst_n            = 1'b0;
        en               = 1'b0;
        cnt              = '0;
        cmp_if.cmp_wvld  = 1'b0;
        @(posedge clk); #1;
        rst_n            = 1'b1;
    endtask

    task automatic wr_cmp(input logic [CW-1:0] val);
        en               = 1'b0;
        cnt              = '0;
        cmp_if.cmp_wdata = val;
        cmp_if.cmp_wvld  = 1'b1;
        @(posedge clk); #1;
        cmp_if.cmp_wvld  = 1'b0;
        check("wr_rdy_drop", cmp_if.cmp_wrdy, 1'b0);
    endtask

    task automatic run_en(input string tag, input int n, input string exp_out,
                          input string exp_vp, input string exp_rdy,
                          input int wr_at, input logic [CW-1:0] wr_val);
        for (int i = 0; i < n; i++) begin
            en  = 1'b1;
            cnt = timer_cnt(i);
            if (i == wr_at) begin
                cmp_if.cmp_wdata = wr_val;
                cmp_if.cmp_wvld  = 1'b1;
            end
            @(posedge clk); #1;
            cmp_if.cmp_wvld = 1'b0;
            check($sformatf("%s_h[%0d]", tag, i), pwm_h, exp_out[i] == "H");
            check($sformatf("%s_l[%0d]", tag, i), pwm_l, exp_out[i] == "L");
            check($sformatf("%s_vp[%0d]", tag, i), valley_pls, exp_vp[i] == "1");
            check($sformatf("%s_rdy[%0d]", tag, i), cmp_if.cmp_wrdy, exp_rdy[i] == "1");
            check($sformatf("%s_ovl[%0d]", tag, i), pwm_h & pwm_l, 1'b0);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        en               = 1'b0;
        cnt              = '0;
        dead_cfg         = '0;
        cmp_if.cmp_wdata = '0;
        cmp_if.cmp_wvld  = 1'b0;
        #1;
        check("rst_h",   pwm_h, 1'b0);
        check("rst_l",   pwm_l, 1'b0);
        check("rst_vp",  valley_pls, 1'b0);
        check("rst_rdy", cmp_if.cmp_wrdy, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic waveform, cmp=2, no dead time.
        wr_cmp(2);
        dead_cfg = 8'd0;
        run_en("basic", 20, "LHHLLLLLHHHLLLLLHHHL", "1........1.......1..",
               "11111111111111111111", -1, '0);

        // One cycle of dead time at every switch.
        do_reset();
        wr_cmp(2);
        dead_cfg = 8'd1;
        run_en("dead1", 20, "--H-LLLL-HH-LLLL-HH-", "1........1.......1..",
               "11111111111111111111", -1, '0);

        // Shadow update: cmp=3 written at cnt=3, applied only after the next valley.
        do_reset();
        wr_cmp(2);
        dead_cfg = 8'd0;
        run_en("shadow", 24, "LHHLLLLLHHHHLLLHHHHHLLLH", "1........1.......1......",
               "111100000111111111111111", 4, 3);

        // Extremes.
        do_reset();
        wr_cmp(0);
        run_en("cmp0", 12, "LLLLLLLLLLLL", "1........1..", "111111111111", -1, '0);
        do_reset();
        wr_cmp(5);
        run_en("cmp5", 12, "LHHHHHHHHHHH", "1........1..", "111111111111", -1, '0);

        // Raw-high window shorter than dead time: high side never asserts.
        do_reset();
        wr_cmp(1);
        dead_cfg = 8'd3;
        run_en("short", 20, "-----LLLL----LLLL---", "1........1.......1..",
               "11111111111111111111", -1, '0);

        // Enable drop while HIGH_ON, then re-enable with active retained.
        do_reset();
        wr_cmp(2);
        dead_cfg = 8'd0;
        run_en("pre_off", 10, "LHHLLLLLHH", "1........1", "1111111111", -1, '0);
        en  = 1'b0;
        cnt = '0;
        @(posedge clk); #1;
        check("en_off_h",  pwm_h, 1'b0);
        check("en_off_l",  pwm_l, 1'b0);
        check("en_off_vp", valley_pls, 1'b0);
        run_en("reen", 12, "HHHLLLLLHHHL", "1........1..", "111111111111", -1, '0);

        // Asynchronous reset in the middle of a cycle with a pending write.
        do_reset();
        wr_cmp(2);
        run_en("pre_rst", 3, "LHH", "1..", "100", 1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_h",   pwm_h, 1'b0);
        check("arst_l",   pwm_l, 1'b0);
        check("arst_vp",  valley_pls, 1'b0);
        check("arst_rdy", cmp_if.cmp_wrdy, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
